fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined successor to the single-cycle core datapath. It owns the fetch PC and runs a request/ready handshake toward the instruction cache/memory. Fetched words are buffered in a DEPTH-entry prefetch queue that feeds decode through a valid/ready handshake. It supports redirects (branch, jump, trap, xRET) with queue flush and discard of in-flight data, and it flags misaligned fetch targets instead of issuing them.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the pipelined core.
// Owns the fetch PC, issues word requests to the instruction memory with a
// req/ready handshake, buffers returned words in a DEPTH-entry prefetch
// queue, and presents the queue head to decode through a valid/ready
// handshake. Redirects flush the queue and discard in-flight data.
// A misaligned redirect target is not fetched; it is queued as a fault entry.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_mem_req           registered fetch request, held until i_mem_ready
//   o_mem_addr          registered word address of the request
//   i_mem_ready         single-cycle completion pulse, i_mem_data valid
//   i_mem_data          fetched instruction word
//   o_valid             queue head valid toward decode
//   o_instr, o_pc       head instruction and its PC
//   o_ex_inst_addr      head entry is a misaligned-fetch fault
//   i_ready             decode accepts the head
//   i_redirect          flush and restart fetch at i_redirect_pc
//   i_redirect_pc       redirect target
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_ex_inst_addr,
  input  logic            i_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic              fault_pend;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [XLEN-1:0]   q_pc    [DEPTH];
  logic [XLEN-1:0]   q_instr [DEPTH];
  logic              q_fault [DEPTH];

  logic              outstanding;
  logic              has_space;
  logic              misaligned;
  logic              push_data;
  logic              push_fault;
  logic              push;
  logic              pop;

  assign outstanding = (state == ST_WAIT) || (state == ST_DROP);
  assign has_space   = count < CNT_W'(DEPTH);
  assign misaligned  = |i_redirect_pc[1:0];

  // Redirect overrides every queue update in its cycle.
  assign push_data  = (state == ST_WAIT) && i_mem_ready && !i_redirect;
  assign push_fault = (state == ST_IDLE) && fault_pend && has_space && !i_redirect;
  assign push       = push_data || push_fault;
  assign pop        = o_valid && i_ready && !i_redirect;

  // Head outputs come straight from the queue; forced to zero when empty.
  assign o_valid        = (count != '0);
  assign o_instr        = o_valid ? q_instr[rd_ptr] : '0;
  assign o_pc           = o_valid ? q_pc[rd_ptr]    : '0;
  assign o_ex_inst_addr = o_valid ? q_fault[rd_ptr] : 1'b0;

  // Queue storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= push_fault ? '0 : i_mem_data;
      q_fault[wr_ptr] <= push_fault;
    end
  end

  // Fetch FSM, request outputs, fetch PC and queue bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      fetch_pc   <= PC_RESET;
      fault_pend <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (i_redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= i_redirect_pc;
      if (outstanding && !i_mem_ready) begin
        // Request still in flight: keep it up (address stable) and drop its data.
        state      <= ST_DROP;
        fault_pend <= misaligned;
      end else if (misaligned) begin
        state      <= ST_IDLE;
        o_mem_req  <= 1'b0;
        fault_pend <= 1'b1;
      end else begin
        // Nothing left in flight and the queue is empty: issue at once.
        state      <= ST_WAIT;
        o_mem_req  <= 1'b1;
        o_mem_addr <= {i_redirect_pc[XLEN-1:2], 2'b00};
        fault_pend <= 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        ST_IDLE: begin
          if (fault_pend) begin
            if (has_space) begin
              fault_pend <= 1'b0;
              state      <= ST_HALT;
            end
          end else if (has_space) begin
            // Only IDLE issues, so count < DEPTH here reserves the slot.
            state      <= ST_WAIT;
            o_mem_req  <= 1'b1;
            o_mem_addr <= {fetch_pc[XLEN-1:2], 2'b00};
          end
        end
        ST_WAIT: begin
          if (i_mem_ready) begin
            fetch_pc  <= fetch_pc + XLEN'(4);
            o_mem_req <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: randomized memory latency, decode backpressure
// and redirects, checked against a stream-level reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ex;
  logic        dec_ready;
  logic        redir;
  logic [31:0] redir_pc;

  fetch_unit #(.XLEN(32), .PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .i_mem_ready    (mem_ready),
    .i_mem_data     (mem_data),
    .o_valid        (valid),
    .o_instr        (instr),
    .o_pc           (pc),
    .o_ex_inst_addr (ex),
    .i_ready        (dec_ready),
    .i_redirect     (redir),
    .i_redirect_pc  (redir_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  // Reference model: the decode stream is PC-sequential from the last
  // reset/redirect target, with each word equal to memf(pc).
  ent_t        mq[$];
  logic [31:0] mfetch;
  bit          fault_pend;
  bit          halted;
  int          redir_cnt;

  // Memory responder state.
  bit          busy;
  int          delay;
  int          epoch;
  int          dmin;
  int          dmax;
  int unsigned ready_pct;

  bit          prev_req;
  bit          prev_pulse;
  logic [31:0] prev_addr;

  int n_assert;
  int n_fail;
  int npops;
  int nfault;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit do_redir, input logic [31:0] rpc, input int when_mode,
                      output bit fired);
    bit   pulse;
    bit   pop;
    bit   push_ok;
    logic s_req;
    check("valid", 32'(valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("head_pc", pc, mq[0].pc);
      check("head_instr", instr, mq[0].instr);
      check("head_fault", 32'(ex), 32'(mq[0].fault));
    end
    if (mem_req && prev_req && !prev_pulse) check("addr_stable", mem_addr, prev_addr);
    if (halted) check("halt_no_req", 32'(mem_req), 32'd0);

    pulse = 1'b0;
    if (mem_req && !busy) begin
      busy  = 1'b1;
      epoch = redir_cnt;
      delay = int'($urandom_range(dmax, dmin));
      check("req_addr", mem_addr, mfetch);
    end
    if (busy) begin
      if (delay == 0) pulse = 1'b1;
      else delay--;
    end
    mem_ready = pulse;
    mem_data  = pulse ? memf(mem_addr) : $urandom();
    fired = do_redir && (when_mode == 0 || (when_mode == 1 && pulse) ||
                         (when_mode == 2 && busy && !pulse));
    redir     = fired;
    redir_pc  = rpc;
    dec_ready = ($urandom_range(99, 0) < ready_pct);
    s_req      = mem_req;
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    prev_pulse = pulse;

    @(posedge clk);
    pop     = (mq.size() != 0) && dec_ready && !fired;
    push_ok = pulse && !fired && (epoch == redir_cnt);
    if (pulse) busy = 1'b0;
    if (pop) begin
      npops++;
      if (mq[0].fault) nfault++;
      void'(mq.pop_front());
    end
    if (fired) begin
      mq.delete();
      redir_cnt++;
      mfetch     = rpc;
      halted     = 1'b0;
      fault_pend = (rpc[1:0] != 2'b00);
    end else begin
      if (push_ok) begin
        mq.push_back('{pc: mfetch, instr: memf(mfetch), fault: 1'b0});
        mfetch = mfetch + 32'd4;
      end
      // A pending fault enters the queue in the first cycle with no request up.
      if (fault_pend && !s_req) begin
        mq.push_back('{pc: mfetch, instr: 32'd0, fault: 1'b1});
        fault_pend = 1'b0;
        halted     = 1'b1;
      end
    end
    @(negedge clk);
    redir     = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    redir     = 1'b0;
    mem_ready = 1'b0;
    dec_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    mq.delete();
    mfetch     = PC_RESET;
    busy       = 1'b0;
    halted     = 1'b0;
    fault_pend = 1'b0;
    redir_cnt++;
    prev_req   = 1'b0;
    prev_pulse = 1'b0;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_ex", 32'(ex), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, PC_RESET);
  endtask

  initial begin
    bit f;
    bit got;
    int n0;
    int nf0;
    int unsigned r;
    rst = 1'b1; redir = 1'b0; redir_pc = '0; mem_ready = 1'b0; mem_data = '0;
    dec_ready = 1'b0;
    n_assert = 0; n_fail = 0; npops = 0; nfault = 0; redir_cnt = 0;
    busy = 1'b0; delay = 0; epoch = 0; dmin = 0; dmax = 0; ready_pct = 0;
    mfetch = PC_RESET; halted = 1'b0; fault_pend = 1'b0;
    prev_req = 1'b0; prev_pulse = 1'b0; prev_addr = '0;
    @(negedge clk);
    do_reset(3);

    // Streaming with fixed memory latency and decode always ready.
    dmin = 2; dmax = 2; ready_pct = 100;
    repeat (24) step(1'b0, 32'd0, 0, f);
    check("stream_pops", 32'(npops >= 3), 32'd1);

    // Backpressure fills the queue exactly, then one pop restarts fetch.
    ready_pct = 0; dmin = 1; dmax = 1;
    repeat (30) step(1'b0, 32'd0, 0, f);
    check("bp_entries", 32'(mq.size()), 32'(DEPTH));
    check("bp_no_req", 32'(mem_req), 32'd0);
    ready_pct = 100;
    step(1'b0, 32'd0, 0, f);
    ready_pct = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (mem_req) got = 1'b1;
      else step(1'b0, 32'd0, 0, f);
    end
    check("bp_reissue", 32'(got), 32'd1);
    repeat (4) step(1'b0, 32'd0, 0, f);

    // Redirect while a request is outstanding: its data must be discarded.
    ready_pct = 100; dmin = 3; dmax = 3;
    f = 1'b0;
    for (int i = 0; i < 30 && !f; i++) step(1'b1, 32'h200, 2, f);
    check("drop_fired", 32'(f), 32'd1);
    n0 = npops;
    repeat (20) step(1'b0, 32'd0, 0, f);
    check("drop_progress", 32'(npops > n0), 32'd1);

    // Redirect coincident with i_mem_ready (and a pop if the head is valid).
    ready_pct = 0; dmin = 1; dmax = 1;
    repeat (6) step(1'b0, 32'd0, 0, f);
    ready_pct = 100;
    f = 1'b0;
    for (int i = 0; i < 30 && !f; i++) step(1'b1, 32'h200, 1, f);
    check("coinc_fired", 32'(f), 32'd1);
    check("coinc_valid", 32'(valid), 32'd0);
    check("coinc_req", 32'(mem_req), 32'd1);
    check("coinc_addr", mem_addr, 32'h200);
    repeat (10) step(1'b0, 32'd0, 0, f);

    // Misaligned redirect produces one fault entry and halts fetch.
    dmin = 0; dmax = 2;
    step(1'b1, 32'h202, 0, f);
    nf0 = nfault;
    repeat (15) step(1'b0, 32'd0, 0, f);
    check("fault_popped", 32'(nfault - nf0), 32'd1);
    check("halt_req", 32'(mem_req), 32'd0);
    step(1'b1, 32'h300, 0, f);
    check("resume_req", 32'(mem_req), 32'd1);
    check("resume_addr", mem_addr, 32'h300);
    repeat (10) step(1'b0, 32'd0, 0, f);

    // Fetch PC wraps through zero.
    step(1'b1, 32'hFFFF_FFF8, 0, f);
    n0 = npops;
    repeat (24) step(1'b0, 32'd0, 0, f);
    check("wrap_progress", 32'(npops - n0 >= 4), 32'd1);

    // Random latency, backpressure and redirects.
    dmin = 0; dmax = 3; ready_pct = 60;
    repeat (600) begin
      r = $urandom_range(99, 0);
      if (r < 3 || (halted && r < 20)) step(1'b1, $urandom() & 32'hFFFF_FFFC, 0, f);
      else if (r < 4) step(1'b1, ($urandom() & 32'hFFFF_FFFC) | 32'h2, 0, f);
      else step(1'b0, 32'd0, 0, f);
    end

    // Reset with a request up and the queue half full.
    step(1'b1, 32'h400, 0, f);
    ready_pct = 0; dmin = 1; dmax = 2;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (mem_req && mq.size() >= 2) got = 1'b1;
      else step(1'b0, 32'd0, 0, f);
    end
    check("reset_setup", 32'(got), 32'd1);
    do_reset(1);
    ready_pct = 100;
    repeat (12) step(1'b0, 32'd0, 0, f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
